fetch_decode_controller: RTL and testbench
==========================================

# fetch_decode_controller

Control unit for the 16-bit programmable processor. It owns the program counter (PC) and the instruction register (IR), and fetches instructions from the synchronous instruction ROM. A Moore state machine decodes each instruction and drives the register-file, data-memory and ALU control lines that the datapath consumes. PC, IR, State and NextState are also exported so the processor top can expose them for debug.

## Interface
- No parameters. Widths are fixed by the ISA: 16-bit instruction, 7-bit PC, 8-bit data address, 4-bit register address.
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- IM_Data  in  16  instruction ROM read data; valid one cycle after IM_Addr is stable
- IM_Addr  out  7  instruction ROM address; equals PC_Out
- PC_Out  out  7  program counter
- IR_Out  out  16  instruction register
- State  out  4  current state encoding
- NextState  out  4  combinational next state
- D_Addr  out  8  data memory address
- D_Wr  out  1  data memory write enable
- RF_s  out  1  register-file write-data select: 1 = data memory, 0 = ALU
- RF_W_en  out  1  register-file write enable
- RF_W_addr  out  4  register-file write address
- RF_Ra_addr  out  4  register-file read port A address
- RF_Rb_addr  out  4  register-file read port B address
- Alu_s0  out  3  ALU function select: 000 pass A, 001 A+B, 010 A−B
- Halted  out  1  high while in the Halt state

## Operation
- ISA: opcode is IR[15:12]. The other fields are fixed per opcode:
  - 0000 NOOP
  - 0001 STORE: D[IR[11:4]] ← RF[IR[3:0]]
  - 0010 LOAD: RF[IR[3:0]] ← D[IR[11:4]]
  - 0011 ADD: RF[IR[3:0]] ← RF[IR[11:8]] + RF[IR[7:4]]
  - 0100 SUB: RF[IR[3:0]] ← RF[IR[11:8]] − RF[IR[7:4]]
  - 0101 HALT
  - 0110–1111 are illegal and execute as NOOP.
- State encoding: Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9. Unused encodings 10–15 go to Init.
- Transitions:
  - Init→Fetch
  - Fetch→Decode
  - Decode→ NoOp / Store / LoadA / Add / Sub / Halt, by opcode
  - LoadA→LoadB
  - NoOp, LoadB, Store, Add, Sub → Fetch
  - Halt→Halt until Reset
- Fetch: IR ← IM_Data and PC ← PC+1 at the end of the cycle. PC wraps 127→0.
- Outputs are Moore, decoded from State and IR only. Default for every control output is 0.
  - LoadA: D_Addr=IR[11:4]. This is the read-setup cycle for synchronous data RAM.
  - LoadB: D_Addr=IR[11:4], RF_s=1, RF_W_en=1, RF_W_addr=IR[3:0].
  - Store: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], Alu_s0=000, D_Wr=1.
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], Alu_s0=001, RF_W_en=1, RF_W_addr=IR[3:0], RF_s=0.
  - Sub: same as Add with Alu_s0=010.
  - Halt: Halted=1. PC and IR are frozen.
- Reset (Reset=0, any time) forces PC=0, IR=0000h, State=Init, and all control outputs to 0 immediately, without waiting for Clk. This includes aborting a Store mid-cycle: D_Wr drops asynchronously.

## Timing
- Reset values: PC_Out=0, IM_Addr=0, IR_Out=0000h, State=0, NextState=1, every control output 0, Halted=0.
- The first Fetch occurs in the second cycle after Reset releases. The Init cycle is the ROM read of address 0.
- Cycles per instruction:
  - NOOP, STORE, ADD, SUB: 3 (Fetch, Decode, execute)
  - LOAD: 4
  - HALT: 2 cycles to reach Halt, then it stays there.
- PC is stable for at least one cycle (Decode or Init) before every Fetch. The registered ROM therefore delivers the correct IM_Data in Fetch.
- IR and PC change only on the Fetch→Decode edge. Register writes and D_Wr commit on the rising edge that ends the execute state.

## Test plan
- Reset held low, then released. Required:
  - State 0 then 1.
  - PC_Out 0→1 on the edge leaving Fetch.
  - IR_Out = ROM[0].
  - All control outputs 0 while Reset is low.
- ROM[0]=3123h (ADD R1+R2→R3). Required: State sequence 1,2,7,1. In state 7: RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, Alu_s0=001, RF_W_en=1.
- ROM = {20A4h, 10A5h} (LOAD D[0Ah]→R4, STORE R5→D[0Ah]). Required:
  - States 1,2,4,5,1,2,6.
  - D_Addr=0Ah in states 4, 5 and 6.
  - RF_s=1 and RF_W_en=1 only in state 5.
  - D_Wr=1 only in state 6.
- ROM[0]=7000h (illegal opcode), ROM[1]=5000h. Required:
  - States 1,2,3,1,2,9.
  - Halted=1 from the state-9 cycle on, and state stays 9 for 20 cycles.
  - PC_Out holds at 2.
- PC at 127 with ROM[127]=0000h. Required: PC_Out wraps to 0 after that Fetch.
- Reset asserted mid-Store (state 6). Required: D_Wr, State and PC_Out clear within the same cycle, before the next Clk edge.

Source files
------------

// File: rtl/fetch_decode_controller.sv
// Fetch/decode control unit: owns PC and IR, sequences each instruction through a Moore FSM
// and decodes State+IR into register-file, data-memory and ALU control lines.
module fetch_decode_controller (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IM_Data,
  output logic [6:0]  IM_Addr,
  output logic [6:0]  PC_Out,
  output logic [15:0] IR_Out,
  output logic [3:0]  State,
  output logic [3:0]  NextState,
  output logic [7:0]  D_Addr,
  output logic        D_Wr,
  output logic        RF_s,
  output logic        RF_W_en,
  output logic [3:0]  RF_W_addr,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  Alu_s0,
  output logic        Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_pc;
  logic [15:0] r_ir;
  logic [3:0]  w_opcode;

  assign w_opcode = r_ir[15:12];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // IR and PC only move on the Fetch->Decode edge, so they are frozen in Halt.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc <= 7'd0;
      r_ir <= 16'h0000;
    end else if (r_state == S_FETCH) begin
      r_pc <= r_pc + 7'd1;
      r_ir <= IM_Data;
    end
  end

  always_comb begin
    w_next     = S_INIT;
    D_Addr     = 8'h00;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = 4'h0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    Alu_s0     = 3'b000;
    Halted     = 1'b0;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          4'h1:    w_next = S_STORE;
          4'h2:    w_next = S_LOADA;
          4'h3:    w_next = S_ADD;
          4'h4:    w_next = S_SUB;
          4'h5:    w_next = S_HALT;
          default: w_next = S_NOOP;
        endcase
      end
      S_NOOP:   w_next = S_FETCH;
      S_LOADA: begin
        w_next = S_LOADB;
        D_Addr = r_ir[11:4];
      end
      S_LOADB: begin
        w_next    = S_FETCH;
        D_Addr    = r_ir[11:4];
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_addr = r_ir[3:0];
      end
      S_STORE: begin
        w_next     = S_FETCH;
        D_Addr     = r_ir[11:4];
        RF_Ra_addr = r_ir[3:0];
        Alu_s0     = 3'b000;
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        w_next     = S_FETCH;
        RF_Ra_addr = r_ir[11:8];
        RF_Rb_addr = r_ir[7:4];
        Alu_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
        RF_W_en    = 1'b1;
        RF_W_addr  = r_ir[3:0];
      end
      S_HALT: begin
        w_next = S_HALT;
        Halted = 1'b1;
      end
      default:  w_next = S_INIT;
    endcase
  end

  assign IM_Addr   = r_pc;
  assign PC_Out    = r_pc;
  assign IR_Out    = r_ir;
  assign State     = r_state;
  assign NextState = w_next;

endmodule

// File: tb/tb_fetch_decode_controller.sv
// Directed bench for fetch_decode_controller with a registered instruction ROM model.
module tb_fetch_decode_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IM_Data;
  logic [6:0]  IM_Addr, PC_Out;
  logic [15:0] IR_Out;
  logic [3:0]  State, NextState;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  Alu_s0;

  logic [15:0] rom [128];
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_decode_controller dut (
    .Clk(Clk), .Reset(Reset), .IM_Data(IM_Data), .IM_Addr(IM_Addr),
    .PC_Out(PC_Out), .IR_Out(IR_Out), .State(State), .NextState(NextState),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .Alu_s0(Alu_s0), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) IM_Data <= rom[IM_Addr];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk({tag, ".D_Addr"},  {8'h0, D_Addr}, 16'h0);
    chk({tag, ".D_Wr"},    {15'h0, D_Wr}, 16'h0);
    chk({tag, ".RF_s"},    {15'h0, RF_s}, 16'h0);
    chk({tag, ".RF_W_en"}, {15'h0, RF_W_en}, 16'h0);
    chk({tag, ".Halted"},  {15'h0, Halted}, 16'h0);
  endtask

  initial begin
    int i;
    clear_rom();
    rom[0] = 16'h3123;

    // Reset held low across clock edges
    step(); step();
    chk("rst.State", {12'h0, State}, 16'd0);
    chk("rst.NextState", {12'h0, NextState}, 16'd1);
    chk("rst.PC", {9'h0, PC_Out}, 16'd0);
    chk("rst.IM_Addr", {9'h0, IM_Addr}, 16'd0);
    chk("rst.IR", IR_Out, 16'h0000);
    chk_ctrl_zero("rst");

    Reset = 1'b1;
    #1;
    chk("init.State", {12'h0, State}, 16'd0);
    step();
    chk("fetch.State", {12'h0, State}, 16'd1);
    chk("fetch.PC", {9'h0, PC_Out}, 16'd0);
    step();
    chk("add.dec.State", {12'h0, State}, 16'd2);
    chk("add.dec.PC", {9'h0, PC_Out}, 16'd1);
    chk("add.dec.IR", IR_Out, 16'h3123);
    chk("add.dec.NextState", {12'h0, NextState}, 16'd7);
    step();
    chk("add.State", {12'h0, State}, 16'd7);
    chk("add.Ra", {12'h0, RF_Ra_addr}, 16'd1);
    chk("add.Rb", {12'h0, RF_Rb_addr}, 16'd2);
    chk("add.Waddr", {12'h0, RF_W_addr}, 16'd3);
    chk("add.Alu", {13'h0, Alu_s0}, 16'b001);
    chk("add.Wen", {15'h0, RF_W_en}, 16'd1);
    chk("add.RF_s", {15'h0, RF_s}, 16'd0);
    chk("add.D_Wr", {15'h0, D_Wr}, 16'd0);
    step();
    chk("add.next.State", {12'h0, State}, 16'd1);

    // Run NOOPs until the Fetch of address 127, then check the wrap
    i = 0;
    while (i < 1000 && !(PC_Out == 7'd127 && State == 4'd1)) begin
      step();
      i++;
    end
    chk("wrap.reach127", {9'h0, PC_Out}, 16'd127);
    chk("wrap.fetchState", {12'h0, State}, 16'd1);
    step();
    chk("wrap.PC", {9'h0, PC_Out}, 16'd0);
    chk("wrap.State", {12'h0, State}, 16'd2);

    // LOAD then STORE, with reset asserted mid-Store
    Reset = 1'b0;
    clear_rom();
    rom[0] = 16'h20A4;
    rom[1] = 16'h10A5;
    step();
    Reset = 1'b1;
    step();
    chk("ls.fetch", {12'h0, State}, 16'd1);
    step();
    chk("ls.dec", {12'h0, State}, 16'd2);
    step();
    chk("ls.loada.State", {12'h0, State}, 16'd4);
    chk("ls.loada.DAddr", {8'h0, D_Addr}, 16'h0A);
    chk("ls.loada.RF_s", {15'h0, RF_s}, 16'd0);
    chk("ls.loada.Wen", {15'h0, RF_W_en}, 16'd0);
    chk("ls.loada.D_Wr", {15'h0, D_Wr}, 16'd0);
    step();
    chk("ls.loadb.State", {12'h0, State}, 16'd5);
    chk("ls.loadb.DAddr", {8'h0, D_Addr}, 16'h0A);
    chk("ls.loadb.RF_s", {15'h0, RF_s}, 16'd1);
    chk("ls.loadb.Wen", {15'h0, RF_W_en}, 16'd1);
    chk("ls.loadb.Waddr", {12'h0, RF_W_addr}, 16'd4);
    chk("ls.loadb.D_Wr", {15'h0, D_Wr}, 16'd0);
    step();
    chk("ls.fetch2", {12'h0, State}, 16'd1);
    step();
    chk("ls.dec2", {12'h0, State}, 16'd2);
    chk("ls.dec2.IR", IR_Out, 16'h10A5);
    step();
    chk("ls.store.State", {12'h0, State}, 16'd6);
    chk("ls.store.DAddr", {8'h0, D_Addr}, 16'h0A);
    chk("ls.store.Ra", {12'h0, RF_Ra_addr}, 16'd5);
    chk("ls.store.D_Wr", {15'h0, D_Wr}, 16'd1);
    chk("ls.store.RF_s", {15'h0, RF_s}, 16'd0);
    chk("ls.store.Wen", {15'h0, RF_W_en}, 16'd0);
    chk("ls.store.Alu", {13'h0, Alu_s0}, 16'b000);
    Reset = 1'b0;
    #1;
    chk("abort.D_Wr", {15'h0, D_Wr}, 16'd0);
    chk("abort.State", {12'h0, State}, 16'd0);
    chk("abort.PC", {9'h0, PC_Out}, 16'd0);
    chk("abort.IR", IR_Out, 16'h0000);

    // Illegal opcode runs as NOOP, then HALT freezes
    clear_rom();
    rom[0] = 16'h7000;
    rom[1] = 16'h5000;
    step();
    Reset = 1'b1;
    step();
    chk("h.fetch", {12'h0, State}, 16'd1);
    step();
    chk("h.dec", {12'h0, State}, 16'd2);
    chk("h.dec.IR", IR_Out, 16'h7000);
    step();
    chk("h.noop", {12'h0, State}, 16'd3);
    chk_ctrl_zero("h.noop");
    step();
    chk("h.fetch2", {12'h0, State}, 16'd1);
    step();
    chk("h.dec2", {12'h0, State}, 16'd2);
    chk("h.dec2.PC", {9'h0, PC_Out}, 16'd2);
    step();
    chk("h.halt.State", {12'h0, State}, 16'd9);
    chk("h.halt.Halted", {15'h0, Halted}, 16'd1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("h.hold.State", {12'h0, State}, 16'd9);
    end
    chk("h.hold.Halted", {15'h0, Halted}, 16'd1);
    chk("h.hold.PC", {9'h0, PC_Out}, 16'd2);
    chk("h.hold.IR", IR_Out, 16'h5000);
    chk("h.hold.NextState", {12'h0, NextState}, 16'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
